// File: rtl/fetch_stream_loader.sv
// fetch_stream_loader: AXI4-Stream sink that packs stream beats into operand
// frames for the SIMD core. Two banks ping-pong, so one frame can be filled
// while the other is being presented. Frames of the wrong length are flagged
// with one-cycle error pulses.
module fetch_stream_loader #(
    parameter int MATRIX_SIZE          = 4,
    parameter int W_IN                 = 8,
    parameter int NUM_OPERANDS         = 8,
    parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                               S_AXIS_ACLK,
    input  logic                                               S_AXIS_ARESETN,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]                    S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]                  S_AXIS_TSTRB,
    input  logic                                               S_AXIS_TLAST,
    input  logic                                               S_AXIS_TVALID,
    output logic                                               S_AXIS_TREADY,
    output logic [NUM_OPERANDS*MATRIX_SIZE*MATRIX_SIZE*W_IN-1:0] data_out,
    output logic                                               frame_valid,
    input  logic                                               frame_ready,
    output logic                                               err_short,
    output logic                                               err_long
);

    localparam int TW          = C_S_AXIS_TDATA_WIDTH;
    localparam int STRB_W      = TW / 8;
    localparam int EPB         = TW / W_IN;
    localparam int FRAME_ELEMS = NUM_OPERANDS * MATRIX_SIZE * MATRIX_SIZE;
    localparam int BEATS       = FRAME_ELEMS / EPB;
    localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic ST_FILL  = 1'b0;
    localparam logic ST_DRAIN = 1'b1;

    // Zero every byte whose strobe bit is clear; lanes are then unpacked
    // directly because lane j of beat b lands at element b*EPB+j, which is
    // the same bit position as the beat word within the frame.
    function automatic logic [TW-1:0] apply_strobe(input logic [TW-1:0] d,
                                                   input logic [STRB_W-1:0] s);
        logic [TW-1:0] r;
        r = '0;
        for (int i = 0; i < STRB_W; i++) begin
            r[i*8 +: 8] = s[i] ? d[i*8 +: 8] : 8'h00;
        end
        return r;
    endfunction

    logic             state;
    logic [CNT_W-1:0] cnt;
    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       full;
    logic [TW-1:0]    bank [2][BEATS];

    logic beat_fire;
    logic at_last;
    logic fill_done;
    logic release_fire;

    assign beat_fire    = S_AXIS_TVALID && S_AXIS_TREADY;
    assign at_last      = (cnt == LAST_BEAT);
    assign fill_done    = beat_fire && (state == ST_FILL) && at_last;
    assign release_fire = frame_valid && frame_ready;

    // DRAIN must keep accepting even with both banks full, otherwise an
    // overlong packet would wedge the stream.
    assign S_AXIS_TREADY = S_AXIS_ARESETN && ((state == ST_DRAIN) || !full[wr_bank]);
    assign frame_valid   = full[rd_bank];

    // Fill state machine, beat counter, bank pointers and error pulses
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state     <= ST_FILL;
            cnt       <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            if (beat_fire) begin
                if (state == ST_FILL) begin
                    if (!at_last) begin
                        // An early TLAST abandons the partial frame in place.
                        cnt       <= S_AXIS_TLAST ? '0 : cnt + 1'b1;
                        err_short <= S_AXIS_TLAST;
                    end else begin
                        cnt     <= '0;
                        wr_bank <= ~wr_bank;
                        if (!S_AXIS_TLAST) begin
                            state <= ST_DRAIN;
                        end
                    end
                end else if (S_AXIS_TLAST) begin
                    err_long <= 1'b1;
                    state    <= ST_FILL;
                end
            end
            if (release_fire) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Full flags: completion sets the write bank, release clears the read
    // bank; both can happen in one cycle because they never hit the same bank.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            full <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (fill_done && (wr_bank == 1'(i))) begin
                    full[i] <= 1'b1;
                end else if (release_fire && (rd_bank == 1'(i))) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    // Bank storage: masked beats are written at the current beat slot
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            for (int bk = 0; bk < 2; bk++) begin
                for (int b = 0; b < BEATS; b++) begin
                    bank[bk][b] <= '0;
                end
            end
        end else if (beat_fire && (state == ST_FILL)) begin
            bank[wr_bank][cnt] <= apply_strobe(S_AXIS_TDATA, S_AXIS_TSTRB);
        end
    end

    // Present the read bank as a flat element vector
    always_comb begin
        data_out = '0;
        for (int b = 0; b < BEATS; b++) begin
            data_out[b*TW +: TW] = bank[rd_bank][b];
        end
    end

endmodule

// File: tb/tb_fetch_stream_loader.sv
// Directed testbench for fetch_stream_loader with default parameters
// (EPB=4, BEATS=32, 128 byte elements per frame).
module tb_fetch_stream_loader;

    localparam int FRAME_W = 1024;

    logic               clk;
    logic               rst_n;
    logic [31:0]        tdata;
    logic [3:0]         tstrb;
    logic               tlast;
    logic               tvalid;
    logic               tready;
    logic [FRAME_W-1:0] data_out;
    logic               frame_valid;
    logic               frame_ready;
    logic               err_short;
    logic               err_long;

    int n_pass;
    int n_total;

    fetch_stream_loader dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rst_n),
        .S_AXIS_TDATA   (tdata),
        .S_AXIS_TSTRB   (tstrb),
        .S_AXIS_TLAST   (tlast),
        .S_AXIS_TVALID  (tvalid),
        .S_AXIS_TREADY  (tready),
        .data_out       (data_out),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .err_short      (err_short),
        .err_long       (err_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
        $fatal(1, "watchdog");
    end

    // Byte j of beat b carries (4*b + j + tag) mod 256.
    function automatic logic [31:0] beat_word(input int b, input int tag);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[j*8 +: 8] = 8'(b * 4 + j + tag);
        return r;
    endfunction

    // Element k of a frame built from beat_word(.., tag) is (k + tag) mod 256.
    function automatic logic [FRAME_W-1:0] exp_frame(input int tag);
        logic [FRAME_W-1:0] r;
        for (int k = 0; k < 128; k++) r[k*8 +: 8] = 8'(k + tag);
        return r;
    endfunction

    // Drive one beat from a falling edge and hold it until it is accepted.
    task automatic drive_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int guard;
        guard  = 0;
        tdata  = d;
        tstrb  = s;
        tlast  = l;
        tvalid = 1'b1;
        while (tready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_total++;
            $display("FAIL beat_timeout: tready=%b after %0d cycles, want 1", tready, guard);
        end
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_beats(input int tag, input int first, input int count, input int last_at);
        for (int b = first; b < first + count; b++) begin
            drive_beat(beat_word(b, tag), 4'hF, (b == last_at));
        end
    endtask

    task automatic pulse_ready();
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_total++;
        if (tready !== 1'b0) $display("FAIL reset_tready: got %b want 0", tready);
        else n_pass++;
        n_total++;
        if (frame_valid !== 1'b0) $display("FAIL reset_frame_valid: got %b want 0", frame_valid);
        else n_pass++;
        n_total++;
        if ({err_short, err_long} !== 2'b00)
            $display("FAIL reset_err: got short=%b long=%b want 0 0", err_short, err_long);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (tready !== 1'b1) $display("FAIL reset_release_tready: got %b want 1", tready);
        else n_pass++;
    endtask

    task automatic test_nominal();
        send_beats(0, 0, 31, 31);
        n_total++;
        if (frame_valid !== 1'b0) $display("FAIL nominal_early_valid: got %b want 0", frame_valid);
        else n_pass++;
        send_beats(0, 31, 1, 31);
        n_total++;
        if (frame_valid !== 1'b1) $display("FAIL nominal_valid: got %b want 1", frame_valid);
        else n_pass++;
        n_total++;
        if (data_out !== exp_frame(0))
            $display("FAIL nominal_data: got low %h want low %h", data_out[127:0], exp_frame(0)[127:0]);
        else n_pass++;
        pulse_ready();
        n_total++;
        if (frame_valid !== 1'b0) $display("FAIL nominal_release: frame_valid got %b want 0", frame_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        time t0;
        logic [FRAME_W-1:0] e;
        t0 = $time;
        send_beats(1, 0, 32, 31);
        send_beats(2, 0, 32, 31);
        n_total++;
        if (($time - t0) != 640) $display("FAIL b2b_cycles: got %0t want 640", $time - t0);
        else n_pass++;
        n_total++;
        if (tready !== 1'b0) $display("FAIL b2b_full_tready: got %b want 0", tready);
        else n_pass++;
        // Third frame offered while both banks are full.
        tdata  = beat_word(0, 3);
        tstrb  = 4'hF;
        tlast  = 1'b0;
        tvalid = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if (tready !== 1'b0) $display("FAIL b2b_stall_tready: got %b want 0", tready);
        else n_pass++;
        n_total++;
        if (data_out !== exp_frame(1) || frame_valid !== 1'b1)
            $display("FAIL b2b_first: valid=%b got low %h want low %h", frame_valid, data_out[127:0], exp_frame(1)[127:0]);
        else n_pass++;
        pulse_ready();
        n_total++;
        if (tready !== 1'b1) $display("FAIL b2b_release_tready: got %b want 1", tready);
        else n_pass++;
        n_total++;
        if (data_out !== exp_frame(2) || frame_valid !== 1'b1)
            $display("FAIL b2b_second: valid=%b got low %h want low %h", frame_valid, data_out[127:0], exp_frame(2)[127:0]);
        else n_pass++;
        send_beats(3, 0, 32, 31);
        pulse_ready();
        e = exp_frame(3);
        n_total++;
        if (data_out !== e || frame_valid !== 1'b1)
            $display("FAIL b2b_third: valid=%b got low %h want low %h", frame_valid, data_out[127:0], e[127:0]);
        else n_pass++;
        pulse_ready();
        n_total++;
        if (frame_valid !== 1'b0) $display("FAIL b2b_empty: frame_valid got %b want 0", frame_valid);
        else n_pass++;
    endtask

    task automatic test_short();
        send_beats(5, 0, 10, 9);
        n_total++;
        if (err_short !== 1'b1 || frame_valid !== 1'b0)
            $display("FAIL short_pulse: err_short=%b frame_valid=%b want 1 0", err_short, frame_valid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (err_short !== 1'b0) $display("FAIL short_pulse_width: err_short got %b want 0", err_short);
        else n_pass++;
        send_beats(6, 0, 32, 31);
        n_total++;
        if (data_out !== exp_frame(6) || frame_valid !== 1'b1)
            $display("FAIL short_next: valid=%b got low %h want low %h", frame_valid, data_out[127:0], exp_frame(6)[127:0]);
        else n_pass++;
        pulse_ready();
    endtask

    task automatic test_long();
        int not_ready;
        not_ready = 0;
        send_beats(7, 0, 32, -1);
        n_total++;
        if (data_out !== exp_frame(7) || frame_valid !== 1'b1)
            $display("FAIL long_frame: valid=%b got low %h want low %h", frame_valid, data_out[127:0], exp_frame(7)[127:0]);
        else n_pass++;
        for (int b = 32; b < 40; b++) begin
            if (tready !== 1'b1) not_ready++;
            drive_beat(32'h55AA55AA ^ 32'(b), 4'hF, (b == 39));
        end
        n_total++;
        if (not_ready != 0) $display("FAIL long_drain_ready: got %0d stalled beats want 0", not_ready);
        else n_pass++;
        n_total++;
        if (err_long !== 1'b1) $display("FAIL long_pulse: err_long got %b want 1", err_long);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (err_long !== 1'b0 || data_out !== exp_frame(7))
            $display("FAIL long_after: err_long=%b low %h want 0 low %h", err_long, data_out[127:0], exp_frame(7)[127:0]);
        else n_pass++;
        pulse_ready();
        send_beats(8, 0, 32, 31);
        n_total++;
        if (data_out !== exp_frame(8) || frame_valid !== 1'b1)
            $display("FAIL long_next: valid=%b got low %h want low %h", frame_valid, data_out[127:0], exp_frame(8)[127:0]);
        else n_pass++;
        pulse_ready();
    endtask

    task automatic test_strobe();
        logic [FRAME_W-1:0] e;
        e = exp_frame(0);
        drive_beat(32'hAABBCCDD, 4'b0101, 1'b0);
        send_beats(0, 1, 31, 31);
        n_total++;
        if (data_out[31:0] !== 32'h00BB00DD)
            $display("FAIL strobe_mask: got %h want 00bb00dd", data_out[31:0]);
        else n_pass++;
        n_total++;
        if (data_out[FRAME_W-1:32] !== e[FRAME_W-1:32])
            $display("FAIL strobe_rest: got %h want %h", data_out[159:32], e[159:32]);
        else n_pass++;
        pulse_ready();
    endtask

    task automatic test_midreset();
        send_beats(9, 0, 32, 31);
        send_beats(10, 0, 10, -1);
        rst_n  = 1'b0;
        tvalid = 1'b0;
        #1;
        n_total++;
        if (tready !== 1'b0 || frame_valid !== 1'b0)
            $display("FAIL midreset_outputs: tready=%b frame_valid=%b want 0 0", tready, frame_valid);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (tready !== 1'b1 || frame_valid !== 1'b0)
            $display("FAIL midreset_release: tready=%b frame_valid=%b want 1 0", tready, frame_valid);
        else n_pass++;
        send_beats(11, 0, 32, 31);
        n_total++;
        if (data_out !== exp_frame(11) || frame_valid !== 1'b1)
            $display("FAIL midreset_frame: valid=%b got low %h want low %h", frame_valid, data_out[127:0], exp_frame(11)[127:0]);
        else n_pass++;
        pulse_ready();
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        rst_n       = 1'b0;
        tdata       = '0;
        tstrb       = '0;
        tlast       = 1'b0;
        tvalid      = 1'b0;
        frame_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_nominal();
        test_back_to_back();
        test_short();
        test_long();
        test_strobe();
        test_midreset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_stream_loader.md
# fetch_stream_loader

AXI4-Stream sink that assembles operand frames for the SIMD core. It is the parametrised successor of the single-buffer fetch sink: it generalises element width, matrix size, operand count and bus width. It adds ping-pong double buffering, TSTRB byte masking, frame-length checking with error pulses, and a valid/ready frame handshake toward the core. It sits between the DMA MM2S stream and the SIMD compute array.

## Interface
Parameters:
- MATRIX_SIZE, 4, matrix dimension N (N×N elements per operand)
- W_IN, 8, element width in bits
- NUM_OPERANDS, 8, matrices per frame
- C_S_AXIS_TDATA_WIDTH, 32, stream width; must be a multiple of W_IN and of 8
- Derived values:
  - EPB = C_S_AXIS_TDATA_WIDTH/W_IN, elements per beat
  - FRAME_ELEMS = NUM_OPERANDS·MATRIX_SIZE²
  - BEATS = FRAME_ELEMS/EPB; FRAME_ELEMS must be a multiple of EPB

Ports:
- S_AXIS_ACLK  in  1  clock, all logic on rising edge
- S_AXIS_ARESETN  in  1  asynchronous, active-low reset
- S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  stream data
- S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  byte qualifier
- S_AXIS_TLAST  in  1  end of packet
- S_AXIS_TVALID  in  1  beat valid
- S_AXIS_TREADY  out  1  sink ready
- data_out  out  FRAME_ELEMS·W_IN  presented frame
- frame_valid  out  1  data_out holds a complete frame
- frame_ready  in  1  core consumes the frame
- err_short  out  1  one-cycle pulse: TLAST before beat BEATS-1
- err_long  out  1  one-cycle pulse: TLAST after beat BEATS-1

## Operation
- Two banks, A and B, each FRAME_ELEMS·W_IN bits.
  - Each bank has a full flag.
  - wr_bank selects the bank being filled; rd_bank selects the bank being presented.
- Beat transfer: a beat transfers when TVALID && TREADY.
- Element packing:
  - TDATA lane j, i.e. TDATA[j·W_IN +: W_IN], becomes element beat·EPB+j.
  - Element k of the frame is at data_out[k·W_IN +: W_IN].
- Byte masking: a byte whose TSTRB bit is 0 is written as 0x00 before unpacking.
- Fill state machine, FILL and DRAIN:
  - FILL, beat counter < BEATS-1:
    - Store the beat and increment the counter.
    - If TLAST=1: pulse err_short, clear the counter, keep wr_bank. The partial frame is discarded and the bank stays empty.
  - FILL, beat counter = BEATS-1:
    - Store the beat, set full[wr_bank], toggle wr_bank, clear the counter.
    - If TLAST=0, go to DRAIN.
  - DRAIN:
    - Accept and discard beats.
    - On the TLAST beat: pulse err_long and return to FILL.
- TREADY = ARESETN && (state==DRAIN || !full[wr_bank]).
- Output side:
  - frame_valid = full[rd_bank] and data_out = bank[rd_bank].
  - On frame_valid && frame_ready: clear full[rd_bank] and toggle rd_bank.
  - data_out is meaningful only while frame_valid=1.
  - data_out is stable while frame_valid && !frame_ready.
- Simultaneous events: frame completion into one bank and release of the other bank in the same cycle both take effect.

## Timing
- Reset (asynchronous, while ARESETN=0):
  - State FILL, counter 0, wr_bank=rd_bank=A, both full flags 0, both banks zeroed.
  - frame_valid=0, err_short=0, err_long=0, TREADY=0.
  - TREADY is 1 in the first cycle after ARESETN rises.
- Reset mid-frame: the partial frame and any held frames are lost. The next beat after release is element 0..EPB-1.
- Latency: frame_valid rises on the clock edge that captures the last beat. It is visible in the cycle after that handshake.
- Throughput: one beat per cycle. Frames can run back-to-back with no bubble while a bank is free.
- Backpressure:
  - With both banks full, TREADY=0 (unless in DRAIN).
  - TREADY rises in the cycle after the frame_valid && frame_ready handshake.
- Frame pacing: the next frame is presented one cycle after release at the earliest.
- Error pulses: err_short and err_long are asserted for exactly the cycle following the offending TLAST beat.
- Counter width: $clog2(BEATS), minimum 1. The counter never exceeds BEATS-1.

## Test plan
All scenarios use the default parameters: EPB=4, BEATS=32.
- Nominal frame:
  - Stimulus: 32 beats, TDATA = 32'h03020100 + b·32'h04040404, TSTRB=4'hF, TLAST on beat 31, frame_ready=0.
  - Response: frame_valid=1 one cycle after beat 31; data_out[k·8 +: 8] = k for k=0..127.
- Backpressure with frame_ready=0:
  - Stimulus: stream 3 frames back-to-back.
  - Response: TREADY=0 after beat 63; the third frame stalls.
  - Then pulse frame_ready for 1 cycle: TREADY=1 the next cycle; the third frame completes; frames are delivered in order.
- Short frame:
  - Stimulus: TLAST on beat 9.
  - Response: err_short pulses for 1 cycle, no frame_valid; the following 32-beat frame is delivered with elements 0..127 correct.
- Long frame:
  - Stimulus: 40 beats, TLAST on beat 39.
  - Response: frame_valid after beat 31; beats 32..39 are accepted with TREADY=1 and discarded; err_long pulses after beat 39; the next frame is intact.
- Strobe masking:
  - Stimulus: beat 0 TDATA=32'hAABBCCDD, TSTRB=4'b0101.
  - Response: elements 0..3 = 8'hDD, 8'h00, 8'hBB, 8'h00.
- Mid-frame reset:
  - Stimulus: ARESETN low after 10 beats, while one full frame is held.
  - Response: TREADY=0 and frame_valid=0 during reset; the post-reset 32-beat frame produces data_out starting at element 0.
